debounce_botones_n: RTL
=======================

# debounce_botones_n

Parametrised N-channel push-button conditioner for the board's user buttons. It sits between the raw button pins and the control FSMs. Per channel it synchronises the raw level, filters bounce with a programmable stable-sample count, and keeps a clean debounced level. It emits one-cycle press and release ticks, plus optional auto-repeat ticks while a button is held.

## Interface
- N, default 4: number of independent button channels (1..16).
- DB_CYCLES, default 4: consecutive cycles the synchronised input must differ from the debounced state before the state flips (>=1).
- EN_REPEAT, default 1: 1 enables auto-repeat; 0 ties repeatr low.
- REPEAT_DELAY, default 8: cycles from the press tick to the first repeat tick (>=1).
- REPEAT_RATE, default 3: cycles between subsequent repeat ticks (>=1).
- clkr  input  1  system clock; all logic on the rising edge.
- resetr_n  input  1  synchronous, active-low reset.
- levelr  input  N  raw asynchronous button levels, active-high (1 = pressed).
- stater  output  N  debounced level per channel.
- pressr  output  N  one-cycle pulse on a debounced 0->1 transition.
- tickr  output  N  one-cycle pulse on a debounced 1->0 transition (release).
- repeatr  output  N  one-cycle auto-repeat pulse while held.

## Operation
- Channels are fully independent. Each channel holds:
  - a 2-FF synchroniser (s1, s2);
  - a debounce counter, width clog2(DB_CYCLES)+1;
  - the stable bit;
  - a repeat FSM with a hold counter sized for max(REPEAT_DELAY, REPEAT_RATE).
- Debounce, evaluated each edge:
  - If s2 == stable: counter <= 0.
  - Else if counter == DB_CYCLES-1: stable <= s2 and counter <= 0 (flip).
  - Else: counter <= counter+1.
- A single sample equal to stable in mid-count (glitch) clears the counter. Counting restarts from 0.
- Ticks are registered and set on the same edge as the flip:
  - pressr[i] = 1 on a flip to 1;
  - tickr[i] = 1 on a flip to 0.
  - Each is 0 on every other cycle. pressr and tickr are never high together on one channel.
- Repeat FSM states: IDLE, DELAY, RATE.
  - IDLE -> DELAY on a press flip; hold counter <= 0.
  - DELAY: counter increments each edge. When the counter == REPEAT_DELAY-1: repeatr pulse, counter <= 0, go to RATE.
  - RATE: counter increments each edge. When the counter == REPEAT_RATE-1: repeatr pulse, counter <= 0, stay in RATE.
  - Any state -> IDLE on a release flip; counter <= 0. The release flip has priority: no repeat pulse on that edge.
  - EN_REPEAT=0: FSM held in IDLE, repeatr constant 0.
- Reset (resetr_n=0 at an edge): s1, s2, stable, counters and ticks all 0, FSM IDLE. Reset overrides all other activity.
- Reset mid-press: the held button is treated as a new press after reset deassertion. pressr fires after the normal latency. No tickr is generated by the reset itself.

## Timing
- Reset values: stater=0, pressr=0, tickr=0, repeatr=0.
- levelr[i] changes before edge k and holds:
  - s1 updates at k, s2 at k+1.
  - The counter counts at edges k+2 .. k+DB_CYCLES+1.
  - stater and pressr/tickr update at edge k+DB_CYCLES+1.
  - Latency is DB_CYCLES+2 edges (6 at the default).
- A press flip at edge E gives repeat pulses at E+REPEAT_DELAY, then every REPEAT_RATE edges after that.
- Pulse width is exactly one clkr cycle for all ticks.
- Bounces shorter than DB_CYCLES cycles (measured at s2) never change stater.

## Test plan
- Reset, defaults: hold resetr_n=0 for 3 cycles with levelr=4'b1111 -> all outputs 0. Release reset -> pressr=4'b1111 for one cycle exactly 6 edges later, stater=4'b1111 thereafter, tickr=0.
- Clean press/release, ch0: levelr[0] 0->1 before edge 10 -> pressr[0] pulse after edge 15. levelr[0] 1->0 before edge 40 -> tickr[0] pulse after edge 45, stater[0]=0. Other channels stay 0.
- Bounce rejection: levelr[1] toggles 1,0,1,0 with 3-cycle phases, then holds 1 -> no tick during the bounce. Single pressr[1] pulse 6 edges after the final rising change.
- Auto-repeat, DELAY=8, RATE=3: press ch2 and hold (pressr at edge E) -> repeatr[2] pulses at E+8, E+11, E+14, … Release -> tickr[2] pulse, no further repeatr pulses, including when the release flip edge equals a scheduled repeat edge.
- EN_REPEAT=0, N=2: hold ch0 for 50 cycles -> repeatr stays 0. pressr and tickr behave as in the clean press/release scenario.
- Reset mid-repeat: channel in RATE, assert resetr_n=0 for one edge with the button still held -> all outputs 0, FSM IDLE. pressr fires again 6 edges after deassertion, and the first repeat comes 8 edges after that.

Source files
------------

// File: rtl/debounce_botones_n.sv
// rtl/debounce_botones_n.sv - N-channel push-button synchroniser, debouncer and auto-repeat
module debounce_botones_n #(
  parameter int N            = 4,
  parameter int DB_CYCLES    = 4,
  parameter int EN_REPEAT    = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 3
) (
  input  logic         clkr,
  input  logic         resetr_n,
  input  logic [N-1:0] levelr,
  output logic [N-1:0] stater,
  output logic [N-1:0] pressr,
  output logic [N-1:0] tickr,
  output logic [N-1:0] repeatr
);

  localparam int DBW  = $clog2(DB_CYCLES) + 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0]  RATE_LAST  = HW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_RATE
  } rep_state_e;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic           s1_q;
    logic           s2_q;
    logic           stable_q;
    logic [DBW-1:0] db_cnt_q;
    rep_state_e     rep_state_q;
    logic [HW-1:0]  hold_cnt_q;
    logic           press_q;
    logic           tick_q;
    logic           repeat_q;
    logic           flip_d;

    // Flip happens on the edge where the mismatch has persisted DB_CYCLES samples.
    assign flip_d = (s2_q != stable_q) && (db_cnt_q == DB_LAST);

    always_ff @(posedge clkr) begin
      if (!resetr_n) begin
        s1_q        <= 1'b0;
        s2_q        <= 1'b0;
        stable_q    <= 1'b0;
        db_cnt_q    <= '0;
        rep_state_q <= REP_IDLE;
        hold_cnt_q  <= '0;
        press_q     <= 1'b0;
        tick_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        s1_q     <= levelr[i];
        s2_q     <= s1_q;
        press_q  <= flip_d && s2_q;
        tick_q   <= flip_d && !s2_q;
        repeat_q <= 1'b0;

        if (s2_q == stable_q) begin
          db_cnt_q <= '0;
        end else if (flip_d) begin
          stable_q <= s2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end

        // Release flip is checked first so it suppresses a coincident repeat pulse.
        if (EN_REPEAT == 0) begin
          rep_state_q <= REP_IDLE;
          hold_cnt_q  <= '0;
        end else if (flip_d && !s2_q) begin
          rep_state_q <= REP_IDLE;
          hold_cnt_q  <= '0;
        end else if (flip_d && s2_q) begin
          rep_state_q <= REP_DELAY;
          hold_cnt_q  <= '0;
        end else begin
          case (rep_state_q)
            REP_DELAY: begin
              if (hold_cnt_q == DELAY_LAST) begin
                repeat_q    <= 1'b1;
                hold_cnt_q  <= '0;
                rep_state_q <= REP_RATE;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
            REP_RATE: begin
              if (hold_cnt_q == RATE_LAST) begin
                repeat_q   <= 1'b1;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
            default: begin
              rep_state_q <= REP_IDLE;
              hold_cnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign stater[i]  = stable_q;
    assign pressr[i]  = press_q;
    assign tickr[i]   = tick_q;
    assign repeatr[i] = repeat_q;
  end

endmodule
